// File: rtl/cpu_state_loader.sv
// cpu_state_loader: debug loader that turns a byte stream into register-file or
// data-memory word writes while holding the pipelined CPU stalled.
//
// Frame: HDR (bit7 target, bits6:0 zero), ADDR, CNT, then CNT little-endian
// 4-byte words. Each completed word gets one WRITE cycle on the selected port.
// Writes to register index 0 are suppressed so r0 stays zero.
//
// Optional build macro LOADER_CHECKSUM_EN: adds a trailing checksum byte
// (XOR of all data bytes, seed 0x00) checked in a CSUM state before DONE.
// A mismatch sets err_o, but words already written stay written.
//
// Every output is taken directly from a flop. Bytes transfer on a rising
// clk_i edge when byte_valid_i and byte_ready_o are both high.

module cpu_state_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              cpu_hold_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    output logic [DATA_W-1:0] rf_data_o,
    output logic              dm_we_o,
    output logic [ADDR_W-1:0] dm_addr_o,
    output logic [DATA_W-1:0] dm_data_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CNT,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    // State entered once the last word is written, or straight from CNT when N=0.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            state_q, state_d;
    logic              target_q, target_d;   // 0 = register file, 1 = data memory
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;         // words still to be written
    logic [1:0]        idx_q, idx_d;         // byte lane of the word being assembled
    logic [DATA_W-1:0] word_q, word_d;
    logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              ready_d, hold_d, done_d, write_d;
    logic              rf_we_d, dm_we_d;
    logic [ADDR_W-1:0] rf_addr_d, dm_addr_d;
    logic [DATA_W-1:0] rf_data_d, dm_data_d;
    logic              accept;

    assign accept = byte_valid_i && byte_ready_o;

    // Next-state, datapath and next-output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        target_d = target_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        word_d   = word_q;
        err_d    = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (byte_data_i[6:0] != 7'd0) begin
                        err_d = 1'b1;    // malformed header: drop it, never hold
                    end else begin
                        target_d = byte_data_i[7];
                        state_d  = S_ADDR;
`ifdef LOADER_CHECKSUM_EN
                        csum_d   = 8'h00;
`endif
                    end
                end
            end
            S_ADDR: begin
                if (accept) begin
                    addr_d  = byte_data_i[ADDR_W-1:0];
                    state_d = S_CNT;
                end
            end
            S_CNT: begin
                if (accept) begin
                    cnt_d   = byte_data_i;
                    idx_d   = 2'd0;
                    word_d  = '0;
                    state_d = (byte_data_i == 8'd0) ? S_TAIL : S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d[{idx_q, 3'b000} +: 8] = byte_data_i;
                    idx_d = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data_i;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);   // wraps modulo 2^ADDR_W
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? S_TAIL : S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    if (byte_data_i != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        // and still line up with the state they describe.
        write_d   = (state_d == S_WRITE);
        ready_d   = (state_d != S_WRITE) && (state_d != S_DONE);
        hold_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        rf_we_d   = write_d && !target_d && (addr_d != '0);
        dm_we_d   = write_d && target_d;
        rf_addr_d = (write_d && !target_d) ? addr_d : '0;
        rf_data_d = (write_d && !target_d) ? word_d : '0;
        dm_addr_d = dm_we_d ? addr_d : '0;
        dm_data_d = dm_we_d ? word_d : '0;
    end

    // State and datapath registers; reset abandons any frame in progress.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            target_q <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= 8'd0;
            idx_q    <= 2'd0;
            word_q   <= '0;
            err_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values.
            state_q  <= state_d;
            target_q <= target_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            err_q    <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            byte_ready_o <= 1'b1;
            cpu_hold_o   <= 1'b0;
            rf_we_o      <= 1'b0;
            rf_addr_o    <= '0;
            rf_data_o    <= '0;
            dm_we_o      <= 1'b0;
            dm_addr_o    <= '0;
            dm_data_o    <= '0;
            done_o       <= 1'b0;
        end else begin
            byte_ready_o <= ready_d;
            cpu_hold_o   <= hold_d;
            rf_we_o      <= rf_we_d;
            rf_addr_o    <= rf_addr_d;
            rf_data_o    <= rf_data_d;
            dm_we_o      <= dm_we_d;
            dm_addr_o    <= dm_addr_d;
            dm_data_o    <= dm_data_d;
            done_o       <= done_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_cpu_state_loader.sv
// tb_cpu_state_loader: directed bench for cpu_state_loader.
// Inputs are driven and outputs sampled on the falling clock edge; a monitor
// logs every write strobe and done pulse for the linear sequence to inspect.
// Build with LOADER_CHECKSUM_EN to send checksum bytes and run checksum cases.

module tb_cpu_state_loader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        byte_ready_o, cpu_hold_o, rf_we_o, dm_we_o, done_o, err_o;
    logic [4:0]  rf_addr_o, dm_addr_o;
    logic [31:0] rf_data_o, dm_data_o;

    int total = 0;
    int bad   = 0;

    logic [36:0] rf_log[$];
    logic [36:0] dm_log[$];
    int          done_cnt = 0;
    int          overlap_cnt = 0;
    logic        hold_at_done = 1'b0;
    logic [7:0]  tb_csum = 8'h00;

    cpu_state_loader #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .cpu_hold_o   (cpu_hold_o),
        .rf_we_o      (rf_we_o),
        .rf_addr_o    (rf_addr_o),
        .rf_data_o    (rf_data_o),
        .dm_we_o      (dm_we_o),
        .dm_addr_o    (dm_addr_o),
        .dm_data_o    (dm_data_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Log strobes and done pulses as seen at each falling edge.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (rf_we_o) rf_log.push_back({rf_addr_o, rf_data_o});
            if (dm_we_o) dm_log.push_back({dm_addr_o, dm_data_o});
            if (done_o) begin
                done_cnt++;
                hold_at_done = cpu_hold_o;
            end
            if (done_o && (rf_we_o || dm_we_o)) overlap_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rf_log.delete();
        dm_log.delete();
        done_cnt = 0;
        overlap_cnt = 0;
        hold_at_done = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        while (!byte_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $error("FAIL send_timeout: observed=not_ready expected=ready byte=%0h", b);
        end
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            tb_csum = tb_csum ^ b;
            send(b);
        end
    endtask

    task automatic start_frame(input logic [7:0] hdr, input logic [7:0] addr, input logic [7:0] cnt);
        tb_csum = 8'h00;
        send(hdr);
        send(addr);
        send(cnt);
    endtask

    task automatic end_frame();
`ifdef LOADER_CHECKSUM_EN
        send(tb_csum);
`endif
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk_i);
        check("reset_flags", {byte_ready_o, cpu_hold_o, rf_we_o, dm_we_o, done_o, err_o}, 6'b100000);
        check("reset_rf_bus", {rf_addr_o, rf_data_o}, 37'd0);
        check("reset_dm_bus", {dm_addr_o, dm_data_o}, 37'd0);
        rst_i = 1'b1;
        @(negedge clk_i);

        // RF load of two words at r1, r2.
        clear_logs();
        send(8'h00);
        check("rf_hold_after_hdr", cpu_hold_o, 1'b1);
        send(8'h01);
        send(8'h02);
        tb_csum = 8'h00;
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        check("rf_hold_in_write", cpu_hold_o, 1'b1);
        end_frame();
        check("rf_write_count", rf_log.size(), 2);
        check("rf_write0", rf_log[0], {5'd1, 32'h12345678});
        check("rf_write1", rf_log[1], {5'd2, 32'hDEADBEEF});
        check("rf_no_dm", dm_log.size(), 0);
        check("rf_done_once", done_cnt, 1);
        check("rf_hold_at_done", hold_at_done, 1'b1);
        check("rf_no_overlap", overlap_cnt, 0);
        check("rf_hold_released", cpu_hold_o, 1'b0);

        // DM load with address wrap 31 -> 0.
        clear_logs();
        start_frame(8'h80, 8'h1F, 8'h02);
        send_word(32'h00000005);
        send_word(32'h00000007);
        end_frame();
        check("dm_write_count", dm_log.size(), 2);
        check("dm_write0", dm_log[0], {5'd31, 32'h00000005});
        check("dm_write1", dm_log[1], {5'd0, 32'h00000007});
        check("dm_no_rf", rf_log.size(), 0);
        check("dm_done_once", done_cnt, 1);

        // r0 write suppressed, address still advances.
        clear_logs();
        start_frame(8'h00, 8'h00, 8'h02);
        send_word(32'h11111111);
        send_word(32'h22222222);
        end_frame();
        check("r0_write_count", rf_log.size(), 1);
        check("r0_write1", rf_log[0], {5'd1, 32'h22222222});
        check("r0_done_once", done_cnt, 1);

        // Bad header, then a valid frame.
        clear_logs();
        send(8'h41);
        check("badhdr_err", err_o, 1'b1);
        check("badhdr_no_hold", cpu_hold_o, 1'b0);
        @(negedge clk_i);
        check("badhdr_still_idle", {cpu_hold_o, byte_ready_o}, 2'b01);
        start_frame(8'h00, 8'h03, 8'h01);
        send_word(32'hA5A5A5A5);
        end_frame();
        check("badhdr_next_write", rf_log[0], {5'd3, 32'hA5A5A5A5});
        check("badhdr_next_count", rf_log.size(), 1);
        check("badhdr_err_sticky", err_o, 1'b1);

        // Reset mid-frame after two data bytes.
        clear_logs();
        start_frame(8'h00, 8'h05, 8'h01);
        send(8'hAA);
        send(8'hBB);
        rst_i = 1'b0;
        #1;
        check("midrst_flags", {byte_ready_o, cpu_hold_o, rf_we_o, dm_we_o, done_o, err_o}, 6'b100000);
        check("midrst_buses", {rf_addr_o, rf_data_o, dm_addr_o, dm_data_o}, 74'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_no_write", rf_log.size() + dm_log.size(), 0);
        start_frame(8'h00, 8'h07, 8'h01);
        send_word(32'h11223344);
        end_frame();
        check("midrst_reload", rf_log[0], {5'd7, 32'h11223344});
        check("midrst_reload_count", rf_log.size(), 1);

`ifdef LOADER_CHECKSUM_EN
        // Good checksum.
        clear_logs();
        start_frame(8'h00, 8'h04, 8'h01);
        send_word(32'h08040201);
        send(8'h0F);
        repeat (3) @(negedge clk_i);
        check("csum_ok_err", err_o, 1'b0);
        check("csum_ok_done", done_cnt, 1);
        check("csum_ok_write", rf_log[0], {5'd4, 32'h08040201});

        // Bad checksum: word still written, done still pulses.
        clear_logs();
        start_frame(8'h00, 8'h05, 8'h01);
        send_word(32'h08040201);
        send(8'h0E);
        repeat (3) @(negedge clk_i);
        check("csum_bad_err", err_o, 1'b1);
        check("csum_bad_done", done_cnt, 1);
        check("csum_bad_write", rf_log[0], {5'd5, 32'h08040201});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
